// File: rtl/switch_box_cfg_loader.sv
// Serial loader for the switch-box config scan chain: takes words over valid/ready
// and shifts them LSB-first onto cfg_bit/cfg_en until CHAIN_LEN bits are loaded.
module switch_box_cfg_loader #(
  parameter int CHAIN_LEN = 20,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              cfg_bit,
  output logic              cfg_en,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bit_count
);

  localparam int BL_W = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t            state, state_nxt;
  logic [WORD_W-1:0] sreg, sreg_nxt;
  logic [BL_W-1:0]   bits_left, bits_left_nxt;
  logic [CNT_W-1:0]  count_nxt;

  always_comb begin
    state_nxt     = state;
    sreg_nxt      = sreg;
    bits_left_nxt = bits_left;
    count_nxt     = bit_count;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state_nxt = LOAD;
            count_nxt = '0;
          end
        end
        LOAD: begin
          if (word_valid) begin
            sreg_nxt      = word_in;
            bits_left_nxt = BL_W'(WORD_W);
            state_nxt     = SHIFT;
          end
        end
        SHIFT: begin
          sreg_nxt      = sreg >> 1;
          bits_left_nxt = bits_left - 1'b1;
          count_nxt     = bit_count + 1'b1;
          // Chain-full wins: leftover bits of the final word are dropped.
          if (bit_count == CNT_W'(CHAIN_LEN - 1))
            state_nxt = DONE;
          else if (bits_left == BL_W'(1))
            state_nxt = LOAD;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next-state values so they line up with state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sreg       <= '0;
      bits_left  <= '0;
      bit_count  <= '0;
      word_ready <= 1'b0;
      cfg_bit    <= 1'b0;
      cfg_en     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      sreg       <= sreg_nxt;
      bits_left  <= bits_left_nxt;
      bit_count  <= count_nxt;
      word_ready <= (state_nxt == LOAD);
      cfg_en     <= (state_nxt == SHIFT);
      cfg_bit    <= (state_nxt == SHIFT) & sreg_nxt[0];
      busy       <= (state_nxt == LOAD) || (state_nxt == SHIFT);
      done       <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_switch_box_cfg_loader.sv
// Scoreboard bench for switch_box_cfg_loader: accepted words push expected bits,
// the cfg_en monitor pops and compares them.
module tb_switch_box_cfg_loader;

  localparam int CL = 20;
  localparam int WW = 8;
  localparam int CW = $clog2(CL + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          word_valid = 1'b0;
  logic [WW-1:0] word_in = '0;
  logic          word_ready, cfg_bit, cfg_en, busy, done;
  logic [CW-1:0] bit_count;

  int checks = 0;
  int errors = 0;
  bit exp_q[$];
  int pushed = 0;
  int pulses = 0;
  logic [CL-1:0] stream = '0;

  switch_box_cfg_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .word_in(word_in), .word_valid(word_valid), .word_ready(word_ready),
    .cfg_bit(cfg_bit), .cfg_en(cfg_en), .busy(busy), .done(done),
    .bit_count(bit_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && cfg_en) begin
      if (exp_q.size() == 0) check("cfg_unexpected", 1, 0);
      else check("cfg_bit", cfg_bit, exp_q.pop_front());
      if (pulses < CL) stream[pulses] = cfg_bit;
      pulses++;
    end
  end

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    exp_q.delete();
    pushed = 0;
    pulses = 0;
    stream = '0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_word(input logic [WW-1:0] w);
    int n;
    @(negedge clk);
    word_in = w;
    word_valid = 1'b1;
    n = 0;
    while (!word_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!word_ready) check("ready_timeout", 0, 1);
    else
      for (int i = 0; i < WW; i++)
        if (pushed < CL) begin
          exp_q.push_back(w[i]);
          pushed++;
        end
    @(negedge clk);
    word_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done, 1);
  endtask

  task automatic check_complete(input string tag, input logic [CL-1:0] exp_stream);
    check({tag, "_count"}, bit_count, CL);
    check({tag, "_pulses"}, pulses, CL);
    check({tag, "_stream"}, stream, exp_stream);
    check({tag, "_q_empty"}, exp_q.size(), 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_cfg_en"}, cfg_en, 0);
  endtask

  initial begin
    int n;
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", word_ready, 0);
    check("rst_cfg_en", cfg_en, 0);
    check("rst_cfg_bit", cfg_bit, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", bit_count, 0);
    rst = 1'b0;

    // Full load; top nibble of 0x0F must be dropped
    do_start();
    check("load_ready", word_ready, 1);
    check("load_busy", busy, 1);
    send_word(8'hA5);
    send_word(8'h3C);
    send_word(8'h0F);
    wait_done();
    check_complete("full", 20'hF3CA5);
    repeat (3) @(negedge clk);
    check("done_hold", done, 1);
    check("done_count_hold", bit_count, CL);
    check("done_no_en", pulses, CL);

    // Reload from DONE
    do_start();
    check("reload_done", done, 0);
    check("reload_count", bit_count, 0);
    check("reload_ready", word_ready, 1);
    send_word(8'h12);
    send_word(8'h34);
    send_word(8'h56);
    wait_done();
    check_complete("reload", 20'h63412);

    // Backpressure: hold word_valid low for 5 LOAD cycles
    do_start();
    send_word(8'h5A);
    n = 0;
    while (!word_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_reach_load", word_ready, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_ready", word_ready, 1);
      check("bp_cfg_en", cfg_en, 0);
      check("bp_count", bit_count, 8);
    end
    send_word(8'hC3);
    send_word(8'h99);
    wait_done();
    check_complete("bp", 20'h9C35A);

    // Ignored start/word_valid while shifting
    do_start();
    send_word(8'h81);
    start = 1'b1;
    word_in = 8'hFF;
    word_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ign_ready", word_ready, 0);
      check("ign_busy", busy, 1);
      check("ign_cfg_en", cfg_en, 1);
    end
    check("ign_count", bit_count, 3);
    start = 1'b0;
    word_valid = 1'b0;
    send_word(8'h7E);
    send_word(8'h24);
    wait_done();
    check_complete("ign", 20'h47E81);

    // Abort at bit_count 11
    do_start();
    send_word(8'hFF);
    send_word(8'h00);
    n = 0;
    while (bit_count != CW'(11) && n < 50) begin
      @(negedge clk);
      n++;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_cfg_en", cfg_en, 0);
    check("abort_count", bit_count, 11);
    check("abort_done", done, 0);
    check("abort_pulses", pulses, 12);
    exp_q.delete();
    // word_valid in IDLE must not handshake
    word_in = 8'hFF;
    word_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_ready", word_ready, 0);
      check("idle_busy", busy, 0);
    end
    word_valid = 1'b0;
    check("idle_count", bit_count, 11);
    do_start();
    check("restart_count", bit_count, 0);
    send_word(8'hA5);
    send_word(8'h3C);
    send_word(8'h0F);
    wait_done();
    check_complete("restart", 20'hF3CA5);

    // Asynchronous reset mid-SHIFT
    do_start();
    send_word(8'h33);
    @(negedge clk);
    check("pre_rst_shift", cfg_en, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_cfg_en", cfg_en, 0);
    check("arst_cfg_bit", cfg_bit, 0);
    check("arst_busy", busy, 0);
    check("arst_ready", word_ready, 0);
    check("arst_count", bit_count, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_done", done, 0);
    check("post_rst_cfg_en", cfg_en, 0);
    do_start();
    check("post_rst_start", word_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
